// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: turns bytes from a UART RX FIFO into register bus accesses.
// Commands are 'W' addr data (write) and 'R' addr (read). A write is acknowledged
// with ACK_BYTE, a read returns the register value, and a bad opcode or an
// inter-byte timeout returns NAK_BYTE. All responses go to the UART TX FIFO.
//
// Ports:
//   clk, rstn          single rising-edge clock, asynchronous active-low reset
//   rxempty, rdata     RX FIFO empty flag and data (data valid the cycle after rduart)
//   rduart             RX FIFO pop strobe
//   txfull             TX FIFO full flag
//   wdata, wruart      TX FIFO write data and write strobe
//   reg_addr/reg_wdata register bus address / write data (hold last captured values)
//   reg_we, reg_re     register write / read strobes
//   reg_rdata          register read data (valid the cycle after reg_re)
//   busy               high whenever the controller is not idle
module uart_reg_ctrl #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxempty,
  input  logic [7:0] rdata,
  output logic       rduart,
  input  logic       txfull,
  output logic [7:0] wdata,
  output logic       wruart,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, POP, LATCH, WR, RD, CAP, SEND} state_t;

  localparam logic [7:0]  OP_W     = 8'h57;
  localparam logic [7:0]  OP_R     = 8'h52;
  localparam logic [16:0] CNT_LAST = 17'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        wait_q, wait_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  hold_q, hold_d;
  logic        rduart_q, rduart_d;
  logic        wruart_q, wruart_d;
  logic        reg_we_q, reg_we_d;
  logic        reg_re_q, reg_re_d;

  // Strobes are registered, so they appear one cycle after the state that
  // requests them. LATCH and CAP therefore wait while the strobe they issued is
  // still high and capture on the following cycle, when the FIFO/register data
  // is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      wait_q   <= 1'b0;
      cnt_q    <= 17'd0;
      opcode_q <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      hold_q   <= 8'h00;
      rduart_q <= 1'b0;
      wruart_q <= 1'b0;
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      rduart_q <= rduart_d;
      wruart_q <= wruart_d;
      reg_we_q <= reg_we_d;
      reg_re_q <= reg_re_d;
    end
  end

  // Next-state logic. wait_q marks the part of LATCH spent waiting for the
  // next command byte, where the timeout counter runs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rxempty) state_d = POP;
      POP:   state_d = LATCH;
      LATCH: begin
        if (wait_q) begin
          if (!rxempty)               state_d = POP;
          else if (cnt_q == CNT_LAST) state_d = SEND;
        end else if (!rduart_q) begin
          case (idx_q)
            2'd0:    if (rdata != OP_W && rdata != OP_R) state_d = SEND;
            2'd1:    if (opcode_q == OP_R) state_d = RD;
            2'd2:    state_d = WR;
            default: state_d = SEND;
          endcase
        end
      end
      WR:    state_d = SEND;
      RD:    state_d = CAP;
      CAP:   if (!reg_re_q) state_d = SEND;
      SEND:  if (!txfull) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and strobe requests for each state.
  always_comb begin
    idx_d    = idx_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    data_d   = data_q;
    hold_d   = hold_q;
    rduart_d = 1'b0;
    wruart_d = 1'b0;
    reg_we_d = 1'b0;
    reg_re_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d  = 2'd0;
        wait_d = 1'b0;
        cnt_d  = 17'd0;
      end
      POP:  rduart_d = 1'b1;
      LATCH: begin
        if (wait_q) begin
          if (!rxempty) begin
            wait_d = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            hold_d = NAK_BYTE;
            wait_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end else if (!rduart_q) begin
          case (idx_q)
            2'd0: begin
              opcode_d = rdata;
              if (rdata != OP_W && rdata != OP_R) begin
                hold_d = NAK_BYTE;
              end else begin
                idx_d  = 2'd1;
                wait_d = 1'b1;
                cnt_d  = 17'd0;
              end
            end
            2'd1: begin
              addr_d = rdata;
              if (opcode_q != OP_R) begin
                idx_d  = 2'd2;
                wait_d = 1'b1;
                cnt_d  = 17'd0;
              end
            end
            2'd2:    data_d = rdata;
            default: hold_d = NAK_BYTE;
          endcase
        end
      end
      WR: begin
        reg_we_d = 1'b1;
        hold_d   = ACK_BYTE;
      end
      RD:   reg_re_d = 1'b1;
      CAP:  if (!reg_re_q) hold_d = reg_rdata;
      SEND: if (!txfull) wruart_d = 1'b1;
      default: ;
    endcase
  end

  // Outputs come straight from flops, so everything reads 0 during reset.
  always_comb begin
    rduart    = rduart_q;
    wruart    = wruart_q;
    reg_we    = reg_we_q;
    reg_re    = reg_re_q;
    wdata     = hold_q;
    reg_addr  = addr_q;
    reg_wdata = data_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb_uart_reg_ctrl: scoreboard bench for uart_reg_ctrl. The main process queues
// RX bytes and the expected register accesses / TX bytes; a monitor on the
// falling clock edge models the RX FIFO and register read data, and pops and
// compares expectations whenever the DUT strobes.
module tb_uart_reg_ctrl;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rstn, rxempty, txfull, rduart, wruart, reg_we, reg_re, busy;
  logic [7:0] rdata, wdata, reg_addr, reg_wdata, reg_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rd_cyc = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_re[$];
  logic [15:0] exp_we[$];

  logic [7:0] rd_value;
  logic [7:0] rd_pend;
  bit         rd_pend_v = 1'b0;
  bit         re_pend_v = 1'b0;
  bit         lat_check = 1'b0;

  uart_reg_ctrl #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rstn(rstn), .rxempty(rxempty), .rdata(rdata), .rduart(rduart),
    .txfull(txfull), .wdata(wdata), .wruart(wruart), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushRx(input logic [7:0] b);
    rxq.push_back(b);
    rxempty = 1'b0;
  endtask

  // Queue n bytes, most significant byte first.
  task automatic applyStimulus(input int n, input logic [23:0] bytes);
    for (int i = n - 1; i >= 0; i--) pushRx(bytes[i*8 +: 8]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (n < budget && !(exp_tx.size() == 0 && exp_we.size() == 0 &&
                           exp_re.size() == 0 && rxq.size() == 0 && !busy)) begin
      tick(1);
      n++;
    end
    if (n >= budget) checkOutput({"timeout_", name}, 32'd0, 32'd1);
    else             checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    tick(2);
  endtask

  task automatic checkReset(input string name);
    checkOutput(name, 32'({rduart, wruart, reg_we, reg_re, busy, wdata, reg_addr, reg_wdata}), 32'd0);
  endtask

  // Monitor: RX FIFO / register data models plus the scoreboard.
  always @(negedge clk) begin
    cyc++;
    rdata     = rd_pend_v ? rd_pend : 8'hEE;
    reg_rdata = re_pend_v ? rd_value : 8'hEE;
    rd_pend_v = 1'b0;
    re_pend_v = 1'b0;
    if (rstn) begin
      if (rduart || reg_we || reg_re || wruart)
        checkOutput("strobe_onehot", 32'($countones({rduart, reg_we, reg_re, wruart})), 32'd1);
      if (rduart) begin
        checkOutput("rduart_when_empty", 32'(rxempty), 32'd0);
        if (rxq.size() > 0) begin
          rd_pend   = rxq.pop_front();
          rd_pend_v = 1'b1;
        end
        rxempty     = (rxq.size() == 0);
        last_rd_cyc = cyc;
      end
      if (reg_we) begin
        if (exp_we.size() == 0) checkOutput("unexpected_reg_we", 32'd1, 32'd0);
        else checkOutput("reg_we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_we.pop_front()));
      end
      if (reg_re) begin
        re_pend_v = 1'b1;
        if (exp_re.size() == 0) checkOutput("unexpected_reg_re", 32'd1, 32'd0);
        else checkOutput("reg_re_addr", 32'(reg_addr), 32'(exp_re.pop_front()));
      end
      if (wruart) begin
        if (exp_tx.size() == 0) checkOutput("unexpected_wruart", 32'd1, 32'd0);
        else checkOutput("tx_byte", 32'(wdata), 32'(exp_tx.pop_front()));
        if (lat_check) begin
          checkOutput("read_latency", 32'(cyc - last_rd_cyc), 32'd6);
          lat_check = 1'b0;
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; rxempty = 1'b1; txfull = 1'b0; rd_value = 8'h00;
    rdata = 8'h00; reg_rdata = 8'h00;
    tick(3);
    checkReset("reset_outputs");
    rstn = 1'b1;
    tick(2);

    // Write command.
    $display("[TB] write 57 10 A5");
    exp_we.push_back(16'h10A5); exp_tx.push_back(8'h06);
    applyStimulus(3, 24'h5710A5);
    waitIdle("write", 100);

    // Read command with all bytes queued; latency from second pop to TX write.
    $display("[TB] read 52 10");
    rd_value = 8'h3C; lat_check = 1'b1;
    exp_re.push_back(8'h10); exp_tx.push_back(8'h3C);
    applyStimulus(2, 24'h005210);
    waitIdle("read", 100);
    checkOutput("latency_measured", 32'(lat_check), 32'd0);
    checkOutput("reg_addr_hold", 32'(reg_addr), 32'h10);
    checkOutput("reg_wdata_hold", 32'(reg_wdata), 32'hA5);

    // Bad opcode, then a normal read.
    $display("[TB] bad opcode 41");
    exp_tx.push_back(8'h15);
    applyStimulus(1, 24'h000041);
    waitIdle("bad_opcode", 100);
    rd_value = 8'h77;
    exp_re.push_back(8'h01); exp_tx.push_back(8'h77);
    applyStimulus(2, 24'h005201);
    waitIdle("read_after_nak", 100);

    // Timeout on a partial write, then a fresh command from idx 0.
    $display("[TB] timeout 57 20");
    exp_tx.push_back(8'h15);
    applyStimulus(2, 24'h005720);
    tick(TO - 10);
    checkOutput("timeout_not_early", 32'(exp_tx.size()), 32'd1);
    checkOutput("timeout_busy", 32'(busy), 32'd1);
    waitIdle("timeout", 100);
    exp_we.push_back(16'h3044); exp_tx.push_back(8'h06);
    applyStimulus(3, 24'h573044);
    waitIdle("write_after_timeout", 100);

    // TX FIFO full holds the response.
    $display("[TB] read 52 05 with txfull");
    txfull = 1'b1; rd_value = 8'h99;
    exp_re.push_back(8'h05); exp_tx.push_back(8'h99);
    applyStimulus(2, 24'h005205);
    tick(20);
    checkOutput("full_busy", 32'(busy), 32'd1);
    checkOutput("full_no_write", 32'(exp_tx.size()), 32'd1);
    checkOutput("full_read_done", 32'(exp_re.size()), 32'd0);
    txfull = 1'b0;
    waitIdle("txfull_release", 100);

    // Reset in the middle of a write command.
    $display("[TB] reset after 57 10");
    applyStimulus(2, 24'h005710);
    begin
      int n = 0;
      while (rxq.size() != 0 && n < 50) begin
        tick(1);
        n++;
      end
      checkOutput("mid_cmd_bytes_popped", 32'(rxq.size()), 32'd0);
    end
    tick(4);
    rstn = 1'b0;
    #1;
    checkReset("reset_mid_cmd");
    tick(2);
    checkReset("reset_held");
    rstn = 1'b1;
    tick(2);
    exp_we.push_back(16'h1122); exp_tx.push_back(8'h06);
    applyStimulus(3, 24'h571122);
    waitIdle("write_after_reset", 100);

    checkOutput("leftover_expectations", 32'(exp_tx.size() + exp_we.size() + exp_re.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_reg_ctrl.md
UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle cycles allowed between bytes of one command.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06: response to a completed write.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15: response to a bad opcode or a timeout.
REQ-004 clk  input  1  single clock; every flop is rising-edge triggered on clk.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 rxempty  input  1  UART RX FIFO empty flag.
REQ-007 rdata  input  8  UART RX FIFO data, valid the cycle after an rduart pulse.
REQ-008 rduart  output  1  RX FIFO pop strobe, one cycle per byte.
REQ-009 txfull  input  1  UART TX FIFO full flag.
REQ-010 wdata  output  8  TX FIFO write data.
REQ-011 wruart  output  1  TX FIFO write strobe, one cycle per byte.
REQ-012 reg_addr  output  8  register bus address.
REQ-013 reg_wdata  output  8  register bus write data.
REQ-014 reg_we  output  1  register write strobe, one cycle.
REQ-015 reg_re  output  1  register read strobe, one cycle.
REQ-016 reg_rdata  input  8  register read data, valid the cycle after reg_re.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL parse commands of the form 'W'(8'h57), addr, data or 'R'(8'h52), addr.
REQ-019 SHALL use these states: IDLE, POP, LATCH, WR, RD, CAP, SEND.
REQ-020 IDLE: SHALL clear byte index idx to 0 and go to POP when rxempty=0.
REQ-021 POP: SHALL assert rduart for exactly one cycle, then go to LATCH.
REQ-022 LATCH: SHALL capture rdata into opcode (idx 0), addr (idx 1) or data (idx 2).
REQ-023 LATCH, idx 0, opcode not 'W' or 'R': SHALL load NAK_BYTE into the TX holding register and go to SEND.
REQ-024 LATCH, command incomplete: SHALL increment idx, reset the timeout counter and wait for rxempty=0, then go to POP.
REQ-025 Command complete: SHALL go to WR for 'W' after idx 2, or to RD for 'R' after idx 1.
REQ-026 WR: SHALL pulse reg_we for one cycle with reg_addr/reg_wdata stable, load ACK_BYTE, then go to SEND.
REQ-027 RD: SHALL pulse reg_re for one cycle, then go to CAP.
REQ-028 CAP: SHALL load reg_rdata into the TX holding register, then go to SEND.
REQ-029 SEND: SHALL hold while txfull=1; when txfull=0, SHALL pulse wruart for one cycle with wdata = holding register, then return to IDLE.
REQ-030 No byte SHALL be dropped or duplicated while txfull=1.
REQ-031 Timeout: a 17-bit counter SHALL run while waiting for byte idx>=1 with rxempty=1.
REQ-032 When the counter reaches TIMEOUT_CYCLES-1, SHALL discard the partial command, load NAK_BYTE and go to SEND.
REQ-033 rduart SHALL never assert when rxempty=1; at most one of rduart, reg_we, reg_re, wruart SHALL be high in any cycle.
REQ-034 Latency: 'R' with bytes already queued and txfull=0 SHALL give wruart 6 cycles after the second rduart.
REQ-035 reg_addr/reg_wdata SHALL hold their last captured values outside strobes.

Reset
REQ-036 rstn=0 SHALL immediately force state IDLE, idx 0, timeout counter 0, and all outputs to 0, including wdata, reg_addr and reg_wdata.
REQ-037 Reset mid-command or mid-SEND SHALL abandon the command with no pending strobe; operation resumes with the first rxempty=0 after rstn=1.

Verification
REQ-038 RX 57,10,A5 with txfull=0 -> one reg_we, reg_addr=10, reg_wdata=A5; TX 06.
REQ-039 RX 52,10 with reg_rdata=3C -> one reg_re, reg_addr=10; TX 3C.
REQ-040 RX 41 -> no register strobe; TX 15; next RX 52,01 handled normally.
REQ-041 RX 57,20, then silence for TIMEOUT_CYCLES (set to 50) -> TX 15, no reg_we; a following command is parsed from idx 0.
REQ-042 RX 52,05 with txfull=1 for 20 cycles -> wruart stays low and busy=1; exactly one write when txfull falls.
REQ-043 rstn=0 pulse after RX 57,10 -> all outputs 0, no reg_we; subsequent 57,11,22 -> reg_we with addr 11, data 22.
